// File: rtl/app_stream_parser.sv
// Application/task word-stream parser: tags each accepted word with field code,
// task index and end-of-application marker, and buffers it toward the packetizer.
module app_stream_parser #(
  parameter int FLIT_SIZE  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  output logic                 credit_o,
  input  logic [FLIT_SIZE-1:0] data_i,
  input  logic                 eoa_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic [3:0]           field_o,
  output logic [FLIT_SIZE-1:0] task_o,
  output logic                 last_o,
  output logic                 err_o,
  output logic                 done_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]          DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [FLIT_SIZE-1:0] ONE     = FLIT_SIZE'(1);

  typedef enum logic [3:0] {
    S_DSZ = 4'd0, S_CNT = 4'd1, S_MAP = 4'd2, S_TAG = 4'd3, S_GRF  = 4'd4,
    S_TSZ = 4'd5, S_DSZ2 = 4'd6, S_BSS = 4'd7, S_ENT = 4'd8, S_BIN = 4'd9
  } state_t;

  typedef struct packed {
    logic [FLIT_SIZE-1:0] data;
    logic [3:0]           field;
    logic [FLIT_SIZE-1:0] tsk;
    logic                 last;
  } entry_t;

  state_t               state_q, state_d;
  logic [FLIT_SIZE-1:0] dsz_q, dsz_d, cnt_q, cnt_d, tsz_q, tsz_d;
  logic [FLIT_SIZE-1:0] t_q, t_d, g_q, g_d, k_q, k_d, b_q, b_d;
  logic [FLIT_SIZE:0]   bin_q, bin_d, sum;
  logic                 err_q, err_d;

  entry_t               mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [AW:0]          occ_q;
  entry_t               wr_e, head;
  logic                 acc, pop, full, go_dsz;

  assign full     = (occ_q == DEPTH_C);
  assign credit_o = rst_ni & ~full;
  assign acc      = rx_i & credit_o;
  assign valid_o  = (occ_q != '0);
  assign pop      = valid_o & ready_i;
  assign sum      = {1'b0, tsz_q} + {1'b0, data_i};

  always_comb begin
    state_d = state_q;
    dsz_d = dsz_q; cnt_d = cnt_q; tsz_d = tsz_q; bin_d = bin_q; err_d = err_q;
    t_d = t_q; g_d = g_q; k_d = k_q; b_d = b_q;
    go_dsz  = 1'b0;
    wr_e.data  = data_i;
    wr_e.field = state_q;
    wr_e.last  = 1'b0;
    wr_e.tsk   = '0;
    if (state_q == S_MAP || state_q == S_TAG) wr_e.tsk = t_q;
    else if (state_q >= S_TSZ)                wr_e.tsk = k_q;
    if (acc) begin
      case (state_q)
        S_DSZ: begin dsz_d = data_i; state_d = S_CNT; end
        S_CNT: begin
          cnt_d = data_i;
          if (data_i != '0)     begin state_d = S_MAP; t_d = '0; end
          else if (dsz_q != '0) begin state_d = S_GRF; g_d = '0; end
          else go_dsz = 1'b1;
        end
        S_MAP: state_d = S_TAG;
        S_TAG: begin
          t_d = t_q + ONE;
          if (t_q + ONE < cnt_q) state_d = S_MAP;
          else if (dsz_q != '0)  begin state_d = S_GRF; g_d = '0; end
          else                   begin state_d = S_TSZ; k_d = '0; end
        end
        S_GRF: begin
          g_d = g_q + ONE;
          if (g_q + ONE < dsz_q)   state_d = S_GRF;
          else if (cnt_q != '0)    begin state_d = S_TSZ; k_d = '0; end
          else go_dsz = 1'b1;
        end
        S_TSZ:  begin tsz_d = data_i; state_d = S_DSZ2; end
        S_DSZ2: begin
          // Bin word count is the byte total in words; a ragged total is flagged, not rounded.
          bin_d = {2'b00, sum[FLIT_SIZE:2]};
          if (sum[1:0] != 2'b00) err_d = 1'b1;
          state_d = S_BSS;
        end
        S_BSS: state_d = S_ENT;
        S_ENT: begin
          if (bin_q != '0) begin state_d = S_BIN; b_d = '0; end
          else if (k_q + ONE < cnt_q) begin state_d = S_TSZ; k_d = k_q + ONE; end
          else go_dsz = 1'b1;
        end
        S_BIN: begin
          b_d = b_q + ONE;
          if ({1'b0, b_q + ONE} < bin_q) state_d = S_BIN;
          else if (k_q + ONE < cnt_q)    begin state_d = S_TSZ; k_d = k_q + ONE; end
          else go_dsz = 1'b1;
        end
        default: state_d = S_DSZ;
      endcase
      if (go_dsz) begin
        state_d   = S_DSZ;
        wr_e.last = 1'b1;
        t_d = '0; g_d = '0; k_d = '0; b_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_DSZ;
      dsz_q <= '0; cnt_q <= '0; tsz_q <= '0; bin_q <= '0; err_q <= 1'b0;
      t_q <= '0; g_q <= '0; k_q <= '0; b_q <= '0;
    end else begin
      state_q <= state_d;
      dsz_q <= dsz_d; cnt_q <= cnt_d; tsz_q <= tsz_d; bin_q <= bin_d; err_q <= err_d;
      t_q <= t_d; g_q <= g_d; k_q <= k_d; b_q <= b_d;
    end
  end

  // Storage needs no reset: every output field is masked by valid_o.
  always_ff @(posedge clk_i) begin
    if (acc) mem_q[wr_q] <= wr_e;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0; rd_q <= '0; occ_q <= '0;
    end else begin
      if (acc) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      case ({acc, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head    = mem_q[rd_q];
  assign data_o  = valid_o ? head.data  : '0;
  assign field_o = valid_o ? head.field : '0;
  assign task_o  = valid_o ? head.tsk   : '0;
  assign last_o  = valid_o & head.last;
  assign err_o   = err_q;
  assign done_o  = eoa_i & (state_q == S_DSZ) & ~valid_o;
endmodule

// File: tb/tb_app_stream_parser.sv
// Directed bench: applications are described at the frame level, expanded into
// expected tagged words, and scored against every cycle the DUT presents a word.
module tb_app_stream_parser;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, rst_n = 1'b0, rx = 1'b0, eoa = 1'b0, ready = 1'b1;
  logic        credit, valid, last, err, done;
  logic [31:0] din = '0, dout, tsk;
  logic [3:0]  fld;

  always #5 clk = ~clk;

  app_stream_parser #(.FLIT_SIZE(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx), .credit_o(credit), .data_i(din),
    .eoa_i(eoa), .valid_o(valid), .ready_i(ready), .data_o(dout), .field_o(fld),
    .task_o(tsk), .last_o(last), .err_o(err), .done_o(done)
  );

  typedef struct { logic [31:0] d; logic [3:0] f; logic [31:0] t; logic l; } exp_t;
  exp_t        expq[$];
  logic [31:0] stim[$];
  int          allow = 1000000;
  int          seq = 0;
  bit          exp_err = 1'b0;
  int          nvec = 0, nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic logic [31:0] nd();
    seq++;
    return 32'h5A00_0000 + seq;
  endfunction

  task automatic add(input logic [31:0] d, input int f, input int t, input bit l);
    exp_t e;
    e.d = d; e.f = f[3:0]; e.t = t; e.l = l;
    stim.push_back(d);
    expq.push_back(e);
  endtask

  // Expand one application into its word sequence with the tags it must carry.
  task automatic app(input int dsz, input int cnt, input int tx, input int dx);
    int bin;
    bin = (tx + dx) / 4;
    add(dsz, 0, 0, 1'b0);
    add(cnt, 1, 0, dsz == 0 && cnt == 0);
    for (int t = 0; t < cnt; t++) begin add(nd(), 2, t, 1'b0); add(nd(), 3, t, 1'b0); end
    for (int g = 0; g < dsz; g++) add(nd(), 4, 0, cnt == 0 && g == dsz - 1);
    for (int k = 0; k < cnt; k++) begin
      add(tx, 5, k, 1'b0);
      add(dx, 6, k, 1'b0);
      add(nd(), 7, k, 1'b0);
      add(nd(), 8, k, bin == 0 && k == cnt - 1);
      for (int b = 0; b < bin; b++) add(nd(), 9, k, k == cnt - 1 && b == bin - 1);
    end
    if (cnt > 0 && ((tx + dx) % 4) != 0) exp_err = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string name, input int n);
    for (int i = 0; i < n && (stim.size() != 0 || expq.size() != 0); i++) tick();
    chk(name, stim.size() + expq.size(), 0);
    tick(); tick();
    chk({name, "_idle"}, valid, 1'b0);
  endtask

  // Source: offers the next word just after each edge; it is taken if credit is up.
  always begin
    @(posedge clk); #1;
    if (allow > 0 && stim.size() != 0) begin
      rx  = 1'b1;
      din = stim[0];
      if (credit) begin
        void'(stim.pop_front());
        allow--;
      end
    end else begin
      rx  = 1'b0;
      din = $urandom;
    end
  end

  // Sink scoreboard: every cycle a word is presented it must match the model head.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (expq.size() == 0) begin
        nvec++; nfail++;
        $display("FAIL spurious_valid: got word %0h expected none", dout);
      end else begin
        chk("data",  dout, expq[0].d);
        chk("field", fld,  expq[0].f);
        chk("task",  tsk,  expq[0].t);
        chk("last",  last, expq[0].l);
        if (ready) void'(expq.pop_front());
      end
    end
  end

  initial begin
    int fref[13];
    int nlast;
    fref = '{0, 1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 9, 9};

    #12;
    chk("rst_credit", credit, 0); chk("rst_valid", valid, 0);
    chk("rst_data", dout, 0);     chk("rst_field", fld, 0);
    chk("rst_task", tsk, 0);      chk("rst_last", last, 0);
    chk("rst_err", err, 0);       chk("rst_done", done, 0);
    tick(); rst_n = 1'b1;
    tick();
    chk("credit_after_rst", credit, 1);

    // T1: full single-task application
    app(2, 1, 8, 4);
    chk("t1_len", expq.size(), 13);
    nlast = 0;
    for (int i = 0; i < 13; i++) begin
      chk("t1_field_pin", expq[i].f, fref[i]);
      chk("t1_task_pin", expq[i].t, 0);
      nlast += int'(expq[i].l);
    end
    chk("t1_last_pin", expq[12].l, 1);
    chk("t1_nlast", nlast, 1);
    wait_drain("t1_drain", 200);
    chk("t1_err", err, 0);

    // T2: empty application then back-to-back graph-only application
    app(0, 0, 0, 0);
    chk("t2_len", expq.size(), 2);
    chk("t2_last_pin", expq[1].l, 1);
    app(2, 0, 0, 0);
    chk("t2_next_field", expq[2].f, 0);
    chk("t2_graph_last", expq[5].l, 1);
    wait_drain("t2_drain", 200);

    // T3: two tasks with zero-length binaries
    app(0, 2, 0, 0);
    chk("t3_len", expq.size(), 14);
    chk("t3_ent0", expq[9].f, 8);
    chk("t3_after_ent0", expq[10].f, 5);
    chk("t3_task1", expq[13].t, 1);
    chk("t3_last", expq[13].l, 1);
    wait_drain("t3_drain", 200);
    chk("t3_err", err, 0);

    // T4: backpressure fills the FIFO exactly
    ready = 1'b0;
    app(2, 1, 8, 4);
    repeat (10) tick();
    chk("t4_accepted", 13 - stim.size(), DEPTH);
    chk("t4_credit_full", credit, 0);
    chk("t4_valid", valid, 1);
    ready = 1'b1;
    tick();
    chk("t4_credit_back", credit, 1);
    wait_drain("t4_drain", 200);

    // T5: ragged byte total flags err, one bin word
    chk("t5_err_before", err, 0);
    app(0, 1, 6, 1);
    chk("t5_len", expq.size(), 9);
    chk("t5_bin_field", expq[8].f, 9);
    wait_drain("t5_drain", 200);
    chk("t5_err", err, 1);
    app(0, 0, 0, 0);
    wait_drain("t5b_drain", 200);
    chk("t5_err_sticky", err, 1);

    // T6: reset in the middle of the binary with two words queued
    allow = 10;
    app(0, 1, 32, 0);
    for (int i = 0; i < 200 && (allow > 0 || expq.size() > 6); i++) tick();
    chk("t6_prefix", expq.size(), 6);
    ready = 1'b0;
    allow = 2;
    for (int i = 0; i < 50 && allow > 0; i++) tick();
    tick(); tick();
    chk("t6_queued_valid", valid, 1);
    chk("t6_queued_n", expq.size(), 6);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", valid, 0);
    chk("t6_rst_credit", credit, 0);
    chk("t6_rst_err", err, 0);
    stim.delete(); expq.delete(); exp_err = 1'b0; allow = 1000000;
    tick(); rst_n = 1'b1; ready = 1'b1;
    eoa = 1'b1;
    add(0, 0, 0, 1'b0);
    for (int i = 0; i < 50 && expq.size() != 0; i++) tick();
    tick();
    chk("t6_done_midframe", done, 0);
    add(0, 1, 0, 1'b1);
    wait_drain("t6_drain", 50);
    chk("t6_done", done, 1);
    chk("t6_err", err, 0);
    eoa = 1'b0;
    tick();
    chk("t6_done_off", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected $finish");
    $fatal(1, "watchdog");
  end
endmodule
